// File: rtl/pulse_cmd_fifo.sv
// Timed pulse-command queue: buffers commands tagged with a qclk timestamp and
// releases each one, in FIFO order, with a one-cycle strobe once qclk reaches it.
module pulse_cmd_fifo #(
    parameter int CMD_WIDTH  = 64,
    parameter int TIME_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [TIME_WIDTH-1:0] qclk_val,
    input  logic                  wr_en,
    input  logic [CMD_WIDTH-1:0]  wr_cmd,
    input  logic [TIME_WIDTH-1:0] wr_time,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic [CMD_WIDTH-1:0]  pulse_cmd,
    output logic                  pulse_valid,
    output logic                  late_err,
    output logic                  overflow_err
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = DEPTH[ADDR_WIDTH:0];

    typedef enum logic [1:0] {ST_EMPTY, ST_WAIT, ST_FIRE} state_t;

    state_t                  state_reg, state_next, ctrl_state;
    logic [CMD_WIDTH-1:0]    cmd_mem  [DEPTH];
    logic [TIME_WIDTH-1:0]   time_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   rd_ptr_reg, wr_ptr_reg;
    logic [ADDR_WIDTH:0]     count_reg;
    logic [CMD_WIDTH-1:0]    pulse_cmd_reg;
    logic                    pulse_valid_reg, late_err_reg, overflow_err_reg;

    logic [TIME_WIDTH-1:0]   head_diff;
    logic                    head_late, head_due;
    logic                    fire, push_ok, overflow_set;

    // Wrap-safe compare: the sign bit of (head_time - qclk) says the head is overdue.
    assign head_diff = time_mem[rd_ptr_reg] - qclk_val;
    assign head_late = head_diff[TIME_WIDTH-1];
    assign head_due  = head_late || (head_diff == '0);

    always_comb begin
        ctrl_state   = state_reg;
        state_next   = state_reg;
        fire         = 1'b0;
        push_ok      = 1'b0;
        overflow_set = 1'b0;
        if (state_reg == ST_WAIT && head_due && !flush) begin
            ctrl_state = ST_FIRE;
        end
        unique case (ctrl_state)
            ST_EMPTY: begin
                push_ok = wr_en && !flush;
                if (push_ok) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                push_ok      = wr_en && !flush && (count_reg != FULL_COUNT);
                overflow_set = wr_en && !flush && (count_reg == FULL_COUNT);
            end
            ST_FIRE: begin
                fire    = 1'b1;
                push_ok = wr_en;
                if (count_reg == 1 && !wr_en) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        if (flush) begin
            state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= ST_EMPTY;
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            pulse_cmd_reg    <= '0;
            pulse_valid_reg  <= 1'b0;
            late_err_reg     <= 1'b0;
            overflow_err_reg <= 1'b0;
        end else if (flush) begin
            state_reg        <= ST_EMPTY;
            rd_ptr_reg       <= '0;
            wr_ptr_reg       <= '0;
            count_reg        <= '0;
            pulse_valid_reg  <= 1'b0;
            late_err_reg     <= 1'b0;
            overflow_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pulse_valid_reg <= fire;
            if (fire) begin
                pulse_cmd_reg <= cmd_mem[rd_ptr_reg];
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
                if (head_late) begin
                    late_err_reg <= 1'b1;
                end
            end
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (push_ok && !fire) begin
                count_reg <= count_reg + 1'b1;
            end else if (fire && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
            if (overflow_set) begin
                overflow_err_reg <= 1'b1;
            end
        end
    end

    // Storage is never reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok && reset) begin
            cmd_mem[wr_ptr_reg]  <= wr_cmd;
            time_mem[wr_ptr_reg] <= wr_time;
        end
    end

    assign full         = (count_reg == FULL_COUNT);
    assign empty        = (count_reg == '0);
    assign count        = count_reg;
    assign pulse_cmd    = pulse_cmd_reg;
    assign pulse_valid  = pulse_valid_reg;
    assign late_err     = late_err_reg;
    assign overflow_err = overflow_err_reg;

endmodule
